axis_tx_arbiter: RTL and testbench
==================================

# axis_tx_arbiter

Packet-granular arbiter that shares the single 64-bit AXI-Stream TX path into the XGS Athena `s_axis_tx_*` slave between two stream sources, port 0 (image DMA) and port 1 (host/test-pattern injector). Grants are held for a whole packet, from the first beat through the beat carrying tlast, so packets are never interleaved. The arbiter counts completed packets per port and raises a one-cycle completion pulse that software and the bench use as an end-of-packet event. It sits in `system_top` between the two sources and the TX slave and is configured through static control inputs driven by the AXI-Lite register file.

## Interface
- DATA_WIDTH, 64, tdata width of all three streams
- USER_WIDTH, 4, tuser width of all three streams
- CNT_WIDTH, 16, width of the per-port packet counters
- aclk  in  1  clock; all logic is rising-edge
- aclk_reset_n  in  1  asynchronous active-low reset
- s0_axis_tvalid / tready / tlast  in/out/in  1 each  port 0 handshake
- s0_axis_tdata / tuser  in  DATA_WIDTH / USER_WIDTH  port 0 payload
- s1_axis_tvalid / tready / tlast  in/out/in  1 each  port 1 handshake
- s1_axis_tdata / tuser  in  DATA_WIDTH / USER_WIDTH  port 1 payload
- m_axis_tvalid / tready / tlast  out/in/out  1 each  output handshake to the TX slave
- m_axis_tdata / tuser  out  DATA_WIDTH / USER_WIDTH  output payload
- cfg_enable  in  1  1 = new grants allowed
- cfg_prio_mode  in  1  0 = round-robin; 1 = fixed priority, port 0 wins
- pkt_cnt0 / pkt_cnt1  out  CNT_WIDTH  packets completed per port; wrap-around
- cnt_clear  in  1  synchronous clear of both counters
- grant  out  2  one-hot current owner; 00 = idle
- irq_pkt  out  1  single-cycle pulse per completed packet

## Operation
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Both s*_axis_tready are 0 and m_axis_tvalid is 0.
  - If cfg_enable=1 and any s*_axis_tvalid=1, the state moves to OWN0 or OWN1 on the next edge.
  - Round-robin: the port not granted last wins when both ports are valid. The last-granted register resets to 1, so port 0 wins the first contest.
  - Fixed priority: port 0 wins whenever s0_axis_tvalid=1.
- OWNn (combinational pass-through of the owning port):
  - m_axis_tvalid = sn_axis_tvalid; m_axis_tdata, tuser and tlast are copied from port n; sn_axis_tready = m_axis_tready.
  - The non-owning port's tready is 0.
  - When the owning port drops tvalid between beats, the grant holds and m_axis_tvalid drops with it.
- Packet completion:
  - Condition: m_axis_tvalid & m_axis_tready & m_axis_tlast.
  - On that edge: pkt_cntn increments, irq_pkt=1 for the following cycle, the last-granted register is set to n, and the state returns to IDLE.
- cfg_enable=0 while in OWNn: the current packet finishes normally. No new grant is issued afterwards.
- cfg_prio_mode is sampled only in IDLE. Changing it mid-packet has no effect on the current packet.
- Counters wrap from 2^CNT_WIDTH-1 to 0 with no flag.
- cnt_clear and a completion on the same edge: the counter ends at 0, because clear wins. irq_pkt still pulses.
- grant reflects the state: OWN0 = 01, OWN1 = 10, IDLE = 00.

## Timing
- Reset (asynchronous assert, synchronous-to-aclk release) forces the following; outputs are held at these values while aclk_reset_n=0:
  - state = IDLE, grant = 00, last-granted = 1
  - pkt_cnt0 = pkt_cnt1 = 0, irq_pkt = 0
  - all s*_axis_tready = 0, m_axis_tvalid = 0
  - m_axis_tdata, tuser, tlast = 0
- Reset mid-packet abandons the packet. After release the arbiter re-arbitrates from IDLE; it does not resume the abandoned packet.
- Arbitration latency: a tvalid seen in IDLE at edge k gives grant at edge k+1. The first beat can transfer in the cycle after edge k+1.
- Datapath latency is zero: combinational pass-through with no registers in the data path.
- Inter-packet bubble: exactly one IDLE cycle between a completing tlast beat and the next grant.
- irq_pkt is high for the one cycle after the tlast transfer edge. Back-to-back packets give pulses 2 cycles apart (one IDLE cycle plus one OWN cycle minimum).
- m_axis_tready low stalls the owning port with no data loss. tdata, tuser and tlast remain those of port n.

## Test plan
- Port 0 sends one 4-beat packet, port 1 idle, m_tready=1 -> grant=01 one cycle after tvalid. 4 beats appear unchanged. pkt_cnt0=1. One irq_pkt pulse. grant returns to 00.
- Both ports hold a 3-beat packet, round-robin mode -> order is port 0, port 1, port 0, port 1 with no interleaved beats. One IDLE cycle between packets. After 4 packets, pkt_cnt0=2 and pkt_cnt1=2.
- Same stimulus with cfg_prio_mode=1 and port 0 always valid -> port 1 is never granted and pkt_cnt1 stays 0.
- During a port 1 packet, toggle m_tready 1,0,0,1 and deassert s1 tvalid for 2 cycles -> all beats are delivered in order, port 0 tready stays 0, and grant holds at 10.
- Drop cfg_enable during beat 2 of 5 -> all 5 beats complete, then grant=00 while valid stays high. Re-enable -> grant is issued 1 cycle later.
- Preload the counter to 0xFFFF and complete 1 packet -> pkt_cnt0=0x0000. Assert aclk_reset_n=0 mid-packet -> all outputs drop to reset values immediately.

Source files
------------

// File: rtl/axis_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// axis_tx_arbiter_if
//   AXI-Stream bundle shared by the two source ports and the output port of
//   axis_tx_arbiter.
//
//   tvalid  source -> sink   beat valid
//   tready  sink   -> source beat accepted
//   tlast   source -> sink   final beat of a packet
//   tdata   source -> sink   DATA_WIDTH payload
//   tuser   source -> sink   USER_WIDTH sideband
//
//   master: the side that drives tvalid/tdata/tuser/tlast
//   slave : the side that drives tready
// -----------------------------------------------------------------------------
interface axis_tx_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 4
);
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_tx_arbiter.sv
// -----------------------------------------------------------------------------
// axis_tx_arbiter
//   Packet-granular two-to-one AXI-Stream arbiter in front of the XGS Athena
//   TX slave. A port owns the output from its first beat through its tlast
//   beat, so packets never interleave. The data path is a purely
//   combinational mux; only the owner state, the round-robin memory, the
//   packet counters and the completion pulse are registered.
//
//   Ports
//     aclk          rising-edge clock
//     aclk_reset_n  asynchronous active-low reset
//     s0_axis       port 0 stream in (image DMA)
//     s1_axis       port 1 stream in (host / test-pattern injector)
//     m_axis        stream out to the TX slave
//     cfg_enable    1 = new grants may be issued
//     cfg_prio_mode 0 = round-robin, 1 = port 0 always wins
//     cnt_clear     synchronous clear of both packet counters
//     pkt_cnt0/1    wrap-around count of completed packets per port
//     grant         one-hot current owner, 00 when idle
//     irq_pkt       one-cycle pulse after each completed packet
// -----------------------------------------------------------------------------
module axis_tx_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 aclk_reset_n,
  axis_tx_arbiter_if.slave     s0_axis,
  axis_tx_arbiter_if.slave     s1_axis,
  axis_tx_arbiter_if.master    m_axis,
  input  logic                 cfg_enable,
  input  logic                 cfg_prio_mode,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] pkt_cnt0,
  output logic [CNT_WIDTH-1:0] pkt_cnt1,
  output logic [1:0]           grant,
  output logic                 irq_pkt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  last_grant;
  logic                  pick_port1;
  logic                  pkt_done;
  logic                  out_valid;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic [USER_WIDTH-1:0] out_user;
  logic                  ready0;
  logic                  ready1;

  // Port 1 wins a fresh grant when it is the only requester, or when both
  // request in round-robin mode and port 0 was the last owner.
  assign pick_port1 = s1_axis.tvalid &&
                      (!s0_axis.tvalid || (!cfg_prio_mode && (last_grant == 1'b0)));

  // Next-state and pass-through mux. Everything defaults to an idle output
  // so the non-owning port never sees tready.
  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    out_user   = '0;
    ready0     = 1'b0;
    ready1     = 1'b0;
    pkt_done   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_enable && (s0_axis.tvalid || s1_axis.tvalid)) begin
          state_next = pick_port1 ? OWN1 : OWN0;
        end
      end
      OWN0: begin
        out_valid = s0_axis.tvalid;
        out_last  = s0_axis.tlast;
        out_data  = s0_axis.tdata;
        out_user  = s0_axis.tuser;
        ready0    = m_axis.tready;
        pkt_done  = s0_axis.tvalid && m_axis.tready && s0_axis.tlast;
        if (pkt_done) begin
          state_next = IDLE;
        end
      end
      OWN1: begin
        out_valid = s1_axis.tvalid;
        out_last  = s1_axis.tlast;
        out_data  = s1_axis.tdata;
        out_user  = s1_axis.tuser;
        ready1    = m_axis.tready;
        pkt_done  = s1_axis.tvalid && m_axis.tready && s1_axis.tlast;
        if (pkt_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_axis.tvalid  = out_valid;
  assign m_axis.tlast   = out_last;
  assign m_axis.tdata   = out_data;
  assign m_axis.tuser   = out_user;
  assign s0_axis.tready = ready0;
  assign s1_axis.tready = ready1;
  assign grant          = {state == OWN1, state == OWN0};

  // Owner state register. Resetting to IDLE forces every output to zero
  // immediately, which also abandons any packet in flight.
  always_ff @(posedge aclk or negedge aclk_reset_n) begin
    if (!aclk_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Round-robin memory, completion pulse and packet counters. The last-granted
  // register starts at port 1 so port 0 wins the first contest. Clear beats a
  // simultaneous increment.
  always_ff @(posedge aclk or negedge aclk_reset_n) begin
    if (!aclk_reset_n) begin
      last_grant <= 1'b1;
      irq_pkt    <= 1'b0;
      pkt_cnt0   <= '0;
      pkt_cnt1   <= '0;
    end else begin
      irq_pkt <= pkt_done;
      if (pkt_done) begin
        last_grant <= (state == OWN1);
      end
      if (cnt_clear) begin
        pkt_cnt0 <= '0;
        pkt_cnt1 <= '0;
      end else if (pkt_done) begin
        if (state == OWN0) begin
          pkt_cnt0 <= pkt_cnt0 + 1'b1;
        end else begin
          pkt_cnt1 <= pkt_cnt1 + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_tx_arbiter
//   Randomized bench for axis_tx_arbiter. Source drivers push every beat they
//   will send into a per-port expected queue; a negedge monitor predicts the
//   owner of the output from the arbitration rules and pops/compares beats,
//   counters and the completion pulse. The counter width is narrowed so the
//   wrap-around case is reachable in a few hundred cycles.
// -----------------------------------------------------------------------------
module tb_axis_tx_arbiter;

  localparam int DW = 64;
  localparam int UW = 4;
  localparam int CW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aclk_reset_n = 1'b0;
  logic          cfg_enable;
  logic          cfg_prio_mode;
  logic          cnt_clear;
  logic [CW-1:0] pkt_cnt0;
  logic [CW-1:0] pkt_cnt1;
  logic [1:0]    grant;
  logic          irq_pkt;

  axis_tx_arbiter_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s0_axis ();
  axis_tx_arbiter_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s1_axis ();
  axis_tx_arbiter_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m_axis ();

  axis_tx_arbiter #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .CNT_WIDTH(CW)) dut (
    .aclk          (aclk),
    .aclk_reset_n  (aclk_reset_n),
    .s0_axis       (s0_axis),
    .s1_axis       (s1_axis),
    .m_axis        (m_axis),
    .cfg_enable    (cfg_enable),
    .cfg_prio_mode (cfg_prio_mode),
    .cnt_clear     (cnt_clear),
    .pkt_cnt0      (pkt_cnt0),
    .pkt_cnt1      (pkt_cnt1),
    .grant         (grant),
    .irq_pkt       (irq_pkt)
  );

  always #5 aclk = ~aclk;

  int    checks = 0;
  int    failures = 0;
  beat_t q0[$];
  beat_t q1[$];
  int    seq[2];
  int    model_owner = -1;
  int    model_last = 1;
  int    exp_cnt[2];
  bit    exp_irq = 1'b0;
  bit    monitor_on = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  int    grant_log[$];
  int    mon_next;
  bit    mon_valid;
  beat_t mon_front;
  int    ready_mode = 0;
  int    pat_idx = 0;
  bit    ready_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit    done0;
  bit    done1;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic drive_port(input int p, input bit v, input beat_t b);
    if (p == 0) begin
      s0_axis.tvalid = v;
      s0_axis.tdata  = b.data;
      s0_axis.tuser  = b.user;
      s0_axis.tlast  = b.last;
    end else begin
      s1_axis.tvalid = v;
      s1_axis.tdata  = b.data;
      s1_axis.tuser  = b.user;
      s1_axis.tlast  = b.last;
    end
  endtask

  function automatic bit port_ready(input int p);
    return (p == 0) ? s0_axis.tready : s1_axis.tready;
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // One packet from port p; beats are queued as expectations before the
  // first one is offered. gap_pct inserts tvalid holes between beats.
  task automatic apply_stimulus(input int p, input int len, input int gap_pct);
    beat_t pkt[$];
    beat_t b;
    bit    fired;
    int    waited;
    for (int i = 0; i < len; i++) begin
      b.data = {8'hA0 + 8'(p), 8'(seq[p]), 8'(i), 8'h00, 32'($urandom)};
      b.user = 4'($urandom);
      b.last = (i == len - 1);
      pkt.push_back(b);
      if (p == 0) q0.push_back(b);
      else q1.push_back(b);
    end
    seq[p]++;
    foreach (pkt[i]) begin
      if (i > 0) begin
        while (int'($urandom_range(99)) < gap_pct) begin
          drive_port(p, 1'b0, pkt[i]);
          idle_cycles(1);
        end
      end
      drive_port(p, 1'b1, pkt[i]);
      fired  = 1'b0;
      waited = 0;
      while (!fired && waited < 1000) begin
        @(negedge aclk);
        fired = port_ready(p);
        @(posedge aclk);
        #1;
        waited++;
      end
      if (!fired) begin
        check_output("handshake_timeout", 64'(fired), 64'd1);
        break;
      end
    end
    drive_port(p, 1'b0, b);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || model_owner >= 0) && n < 2000) begin
      idle_cycles(1);
      n++;
    end
    check_output("drain", (q0.size() == 0 && q1.size() == 0) ? 64'd1 : 64'd0, 64'd1);
    idle_cycles(2);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    model_owner = -1;
    model_last  = 1;
    exp_cnt[0]  = 0;
    exp_cnt[1]  = 0;
    exp_irq     = 1'b0;
    prev_grant  = 2'b00;
  endtask

  // Output ready generator: always ready, fixed 1,0,0,1 pattern, or random.
  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        1: begin
          m_axis.tready = ready_pat[pat_idx % 4];
          pat_idx++;
        end
        2: m_axis.tready = ($urandom_range(99) < 70);
        default: m_axis.tready = 1'b1;
      endcase
    end
  end

  // Monitor / reference model. Owner is predicted at packet level: an idle
  // cycle with an enabled request hands the output to the winner for the
  // next cycle; a popped beat marked last ends ownership.
  always @(negedge aclk) begin
    if (monitor_on && aclk_reset_n) begin
      check_output("irq_pkt", 64'(irq_pkt), 64'(exp_irq));
      check_output("pkt_cnt0", 64'(pkt_cnt0), 64'(exp_cnt[0]));
      check_output("pkt_cnt1", 64'(pkt_cnt1), 64'(exp_cnt[1]));
      if (prev_grant == 2'b00 && grant != 2'b00) grant_log.push_back((grant == 2'b10) ? 1 : 0);
      prev_grant = grant;
      exp_irq  = 1'b0;
      mon_next = model_owner;
      if (model_owner < 0) begin
        check_output("idle_grant", 64'(grant), 64'd0);
        check_output("idle_m_tvalid", 64'(m_axis.tvalid), 64'd0);
        check_output("idle_s0_tready", 64'(s0_axis.tready), 64'd0);
        check_output("idle_s1_tready", 64'(s1_axis.tready), 64'd0);
        if (cfg_enable && (s0_axis.tvalid || s1_axis.tvalid)) begin
          if (s0_axis.tvalid && s1_axis.tvalid) mon_next = cfg_prio_mode ? 0 : 1 - model_last;
          else mon_next = s0_axis.tvalid ? 0 : 1;
        end
      end else begin
        mon_valid = (model_owner == 0) ? s0_axis.tvalid : s1_axis.tvalid;
        check_output("own_grant", 64'(grant), (model_owner == 0) ? 64'd1 : 64'd2);
        check_output("own_m_tvalid", 64'(m_axis.tvalid), 64'(mon_valid));
        check_output("s0_tready", 64'(s0_axis.tready),
                     (model_owner == 0) ? 64'(m_axis.tready) : 64'd0);
        check_output("s1_tready", 64'(s1_axis.tready),
                     (model_owner == 1) ? 64'(m_axis.tready) : 64'd0);
        if (mon_valid) begin
          if ((model_owner == 0 && q0.size() == 0) || (model_owner == 1 && q1.size() == 0)) begin
            check_output("beat_expected", 64'd0, 64'd1);
          end else begin
            mon_front = (model_owner == 0) ? q0[0] : q1[0];
            check_output("m_tdata", m_axis.tdata, mon_front.data);
            check_output("m_tuser", 64'(m_axis.tuser), 64'(mon_front.user));
            check_output("m_tlast", 64'(m_axis.tlast), 64'(mon_front.last));
            if (m_axis.tready) begin
              if (model_owner == 0) void'(q0.pop_front());
              else void'(q1.pop_front());
              if (mon_front.last) begin
                exp_cnt[model_owner] = (exp_cnt[model_owner] + 1) % (1 << CW);
                exp_irq    = 1'b1;
                model_last = model_owner;
                mon_next   = -1;
              end
            end
          end
        end
      end
      if (cnt_clear) begin
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
      end
      model_owner = mon_next;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    beat_t z;
    int    exp_order[5];
    int    ok;
    z = '0;
    drive_port(0, 1'b0, z);
    drive_port(1, 1'b0, z);
    cfg_enable    = 1'b1;
    cfg_prio_mode = 1'b0;
    cnt_clear     = 1'b0;
    seq[0] = 0;
    seq[1] = 0;
    model_reset();

    // Reset values while reset is held, with a request pending.
    drive_port(0, 1'b1, z);
    #12;
    check_output("rst_grant", 64'(grant), 64'd0);
    check_output("rst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
    check_output("rst_s0_tready", 64'(s0_axis.tready), 64'd0);
    check_output("rst_cnt0", 64'(pkt_cnt0), 64'd0);
    check_output("rst_irq", 64'(irq_pkt), 64'd0);
    drive_port(0, 1'b0, z);
    repeat (2) @(posedge aclk);
    #3;
    aclk_reset_n = 1'b1;
    monitor_on   = 1'b1;
    @(posedge aclk);
    #1;

    // Both ports with two 3-beat packets each, round-robin.
    grant_log.delete();
    fork
      begin apply_stimulus(0, 3, 0); apply_stimulus(0, 3, 0); end
      begin apply_stimulus(1, 3, 0); apply_stimulus(1, 3, 0); end
    join
    wait_drain();
    exp_order = '{0, 1, 0, 1, 0};
    check_output("rr_log_size", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_output("rr_order", 64'(grant_log[i]), 64'(exp_order[i]));
    check_output("rr_cnt0", 64'(pkt_cnt0), 64'd2);
    check_output("rr_cnt1", 64'(pkt_cnt1), 64'd2);

    // Single 4-beat packet on port 0: grant one cycle after tvalid.
    fork
      apply_stimulus(0, 4, 0);
      begin
        @(negedge aclk);
        check_output("a_grant_first", 64'(grant), 64'd0);
        @(negedge aclk);
        check_output("a_grant_next", 64'(grant), 64'd1);
      end
    join
    wait_drain();
    check_output("a_cnt0", 64'(pkt_cnt0), 64'd3);

    // Fixed priority: port 0 back-to-back keeps port 1 out.
    cfg_prio_mode = 1'b1;
    grant_log.delete();
    fork
      begin for (int k = 0; k < 4; k++) apply_stimulus(0, 3, 0); end
      apply_stimulus(1, 3, 0);
    join
    wait_drain();
    exp_order = '{0, 0, 0, 0, 1};
    check_output("prio_log_size", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check_output("prio_order", 64'(grant_log[i]), 64'(exp_order[i]));
    cfg_prio_mode = 1'b0;

    // Port 1 packet under a 1,0,0,1 ready pattern with tvalid holes.
    ready_mode = 1;
    pat_idx    = 0;
    apply_stimulus(1, 5, 40);
    wait_drain();
    ready_mode = 0;
    idle_cycles(1);

    // Drop cfg_enable during beat 2 of 5, then re-enable.
    fork
      apply_stimulus(0, 5, 0);
      begin
        ok = 0;
        for (int n = 0; n < 50 && ok == 0; n++) begin
          @(negedge aclk);
          if (grant == 2'b01) ok = 1;
        end
        check_output("en_grant_seen", 64'(ok), 64'd1);
        idle_cycles(1);
        cfg_enable = 1'b0;
      end
    join
    fork
      apply_stimulus(0, 2, 0);
      begin
        repeat (4) begin
          @(negedge aclk);
          check_output("en_off_grant", 64'(grant), 64'd0);
        end
        idle_cycles(1);
        cfg_enable = 1'b1;
        @(negedge aclk);
        check_output("en_on_idle", 64'(grant), 64'd0);
        @(negedge aclk);
        check_output("en_on_grant", 64'(grant), 64'd1);
      end
    join
    wait_drain();

    // Randomized traffic with config churn and counter clears.
    ready_mode = 2;
    done0 = 1'b0;
    done1 = 1'b0;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          apply_stimulus(0, $urandom_range(1, 6), 30);
          idle_cycles($urandom_range(0, 2));
        end
        done0 = 1'b1;
      end
      begin
        for (int k = 0; k < 20; k++) begin
          apply_stimulus(1, $urandom_range(1, 6), 30);
          idle_cycles($urandom_range(0, 2));
        end
        done1 = 1'b1;
      end
      begin
        while (!(done0 && done1)) begin
          idle_cycles(1);
          if ($urandom_range(9) == 0) cfg_prio_mode = ~cfg_prio_mode;
          cfg_enable = ($urandom_range(9) != 0);
          cnt_clear  = ($urandom_range(39) == 0);
        end
        cfg_enable = 1'b1;
        cnt_clear  = 1'b0;
      end
    join
    wait_drain();
    ready_mode    = 0;
    cfg_prio_mode = 1'b0;
    idle_cycles(1);

    // Counter wrap on port 0.
    cnt_clear = 1'b1;
    idle_cycles(1);
    cnt_clear = 1'b0;
    for (int k = 0; k < (1 << CW) - 1; k++) apply_stimulus(0, 1, 0);
    @(negedge aclk);
    check_output("wrap_max", 64'(pkt_cnt0), 64'((1 << CW) - 1));
    idle_cycles(1);
    apply_stimulus(0, 1, 0);
    @(negedge aclk);
    check_output("wrap_zero", 64'(pkt_cnt0), 64'd0);
    wait_drain();

    // Reset in the middle of a port 1 packet.
    monitor_on = 1'b0;
    z.data = 64'hDEAD_BEEF_0000_0001;
    z.user = 4'h5;
    z.last = 1'b0;
    drive_port(1, 1'b1, z);
    ok = 0;
    for (int n = 0; n < 20 && ok == 0; n++) begin
      @(negedge aclk);
      if (grant == 2'b10) ok = 1;
    end
    check_output("mid_grant_seen", 64'(ok), 64'd1);
    @(posedge aclk);
    #3;
    aclk_reset_n = 1'b0;
    #1;
    check_output("mid_rst_grant", 64'(grant), 64'd0);
    check_output("mid_rst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
    check_output("mid_rst_m_tdata", m_axis.tdata, 64'd0);
    check_output("mid_rst_m_tuser", 64'(m_axis.tuser), 64'd0);
    check_output("mid_rst_m_tlast", 64'(m_axis.tlast), 64'd0);
    check_output("mid_rst_s1_tready", 64'(s1_axis.tready), 64'd0);
    check_output("mid_rst_cnt0", 64'(pkt_cnt0), 64'd0);
    check_output("mid_rst_cnt1", 64'(pkt_cnt1), 64'd0);
    check_output("mid_rst_irq", 64'(irq_pkt), 64'd0);
    drive_port(1, 1'b0, z);
    repeat (2) @(posedge aclk);
    #3;
    model_reset();
    grant_log.delete();
    aclk_reset_n = 1'b1;
    monitor_on   = 1'b1;
    idle_cycles(1);
    apply_stimulus(1, 3, 0);
    wait_drain();
    check_output("post_rst_log_size", 64'(grant_log.size()), 64'd1);
    if (grant_log.size() > 0) check_output("post_rst_owner", 64'(grant_log[0]), 64'd1);
    check_output("post_rst_cnt1", 64'(pkt_cnt1), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
